sam_mem_responder: RTL and testbench
====================================

// Module: sam_mem_responder
// PURPOSE
//   Memory-side responder for the SAM multiplexed address/data bus (ALE, En, Rw).
//   Latches the address on an ALE cycle. Returns read data when En=1 and Rw=1.
//   Commits a write when En=1 and Rw=0.
//   Holds a DEPTH x 8 register-array memory. A side program port loads it while the CPU is paused.
// PARAMETERS
//   DEPTH    256  memory words; address uses the low clog2(DEPTH) bits of the bus
//   ROM_TOP  0    addresses < ROM_TOP are write-protected from the bus (program port may still write)
// PORTS
//   clk        in   1   system clock; all state changes on posedge
//   rst        in   1   asynchronous, active-low reset
//   ale        in   1   address latch enable from CPU
//   en         in   1   memory access strobe from CPU
//   rw         in   1   1 = read, 0 = write
//   bus_in     in   8   value the CPU drives on the shared bus (address or write data)
//   bus_out    out  8   read data toward CPU
//   bus_oe     out  1   responder drives bus (bus_out valid)
//   prog_req   in   1   program-port request (level)
//   prog_addr  in   8   program-port address
//   prog_data  in   8   program-port write data
//   prog_ack   out  1   one-cycle pulse: program write committed
//   err        out  1   sticky error flag; cleared only by reset
//   rd_cnt     out  16  completed bus reads, saturating at 16'hFFFF
//   wr_cnt     out  16  committed bus writes, saturating at 16'hFFFF
// BEHAVIOUR
//   Reset (rst=0, async): clears addr_q, addr_vld, err, rd_cnt and wr_cnt.
//     Puts the FSM in IDLE. Outputs: bus_out=0, bus_oe=0, prog_ack=0.
//     Memory contents are NOT cleared.
//   FSM states: IDLE, ADDR, RD, WR, PROG.
//   Posedge with ale=1: addr_q<=bus_in, addr_vld<=1, state->ADDR.
//     ALE has priority over en/rw: no access happens that cycle, even with en=1.
//   Posedge with ale=0, en=1, rw=1:
//     addr_vld=1: rd_q<=mem[addr_q], rd_cnt+1, state->RD.
//     addr_vld=0: err<=1, no read, state->IDLE.
//   RD state: bus_oe=1 and bus_out=rd_q, registered.
//     Read latency is 1 cycle from the sampled En edge.
//     bus_oe stays high while en=1 and rw=1. Consecutive En cycles re-read the same addr_q.
//     bus_oe drops the cycle after en falls, or immediately on the next ale.
//   Posedge with ale=0, en=1, rw=0 and addr_vld=1:
//     addr_q >= ROM_TOP: mem[addr_q]<=bus_in, wr_cnt+1, state->WR.
//     addr_q < ROM_TOP: write dropped, err<=1.
//     addr_vld=0: err<=1.
//   The write commits on the En edge. rw=0 together with ale=1 is only an address phase.
//   WR/RD/ADDR return to IDLE when en=0 and ale=0. addr_q and addr_vld persist until the next ale.
//     Back-to-back accesses to one address need no new ALE.
//   PROG: entered from IDLE only, when prog_req=1 and ale=0 and en=0.
//     Next posedge: mem[prog_addr]<=prog_data (ignores ROM_TOP), prog_ack=1 for one cycle.
//     Then waits in PROG until prog_req=0, then goes to IDLE.
//     prog_req while the CPU bus is active (ale or en) is deferred, not dropped.
//   Bus activity (ale or en) seen while in PROG: err<=1 and the bus access is ignored.
//     No address is latched and no data is driven.
//   Address wrap: bus_in values >= DEPTH alias modulo DEPTH. No error is raised.
//   Counters saturate and never wrap.
//   Reset mid-access: bus_oe drops asynchronously. A write already committed on a prior edge stands.
// TESTING
//   prog writes mem[0x10]=0x6A, then ale with bus_in=0x10, then en=1/rw=1
//     -> bus_oe=1, bus_out=0x6A one cycle after the en edge; rd_cnt=1.
//   ale with bus_in=0x20, then en=1/rw=0 with bus_in=0x5C, then read back 0x20
//     -> returns 0x5C; wr_cnt=1; err=0.
//   ROM_TOP=0x40: bus write of 0x99 to 0x05
//     -> mem[0x05] unchanged, err=1; a prog write to 0x05 succeeds, prog_ack pulses once.
//   ale=1 and en=1 in the same cycle with bus_in=0x30
//     -> addr_q=0x30, no read or write, bus_oe=0, counters unchanged.
//   en=1/rw=1 right after reset, with no ale -> err=1, bus_oe stays 0.
//   Assert rst=0 in the middle of the RD state
//     -> bus_oe=0 asynchronously; the next read needs a fresh ale.

Source files
------------

// File: rtl/sam_mem_responder_if.sv
// SAM multiplexed address/data bus between a CPU (master) and a memory responder (slave).
// The CPU drives ale/en/rw/bus_in; the responder returns bus_out qualified by bus_oe.
interface sam_mem_responder_if;
    logic       ale;
    logic       en;
    logic       rw;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;

    modport master (
        output ale,
        output en,
        output rw,
        output bus_in,
        input  bus_out,
        input  bus_oe
    );

    modport slave (
        input  ale,
        input  en,
        input  rw,
        input  bus_in,
        output bus_out,
        output bus_oe
    );
endinterface

// File: rtl/sam_mem_responder.sv
// Memory-side responder for the SAM bus: latches addresses on ALE, serves reads and writes
// from a register-array memory, and accepts side-channel program writes while the CPU is idle.
module sam_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ROM_TOP = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    sam_mem_responder_if.slave    bus,
    input  logic                  prog_req_i,
    input  logic [7:0]            prog_addr_i,
    input  logic [7:0]            prog_data_i,
    output logic                  prog_ack_o,
    output logic                  err_o,
    output logic [15:0]           rd_cnt_o,
    output logic [15:0]           wr_cnt_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD,
        WR,
        PROG
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          addrVld_q, addrVld_d;
    logic [7:0]    rd_q, rd_d;
    logic          err_q, err_d;
    logic          progAck_q, progAck_d;
    logic [15:0]   rdCnt_q, rdCnt_d;
    logic [15:0]   wrCnt_q, wrCnt_d;

    logic [7:0]    mem_q [DEPTH];
    logic          memWe;
    logic [AW-1:0] memWaddr;
    logic [7:0]    memWdata;
    logic          romHit;

    generate
        if (ROM_TOP == 0) begin : gNoRom
            assign romHit = 1'b0;
        end else begin : gRom
            assign romHit = ({{(32-AW){1'b0}}, addr_q} < ROM_TOP);
        end
    endgenerate

    // ALE outranks any strobe; a pending program request is only taken from a quiet IDLE.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        addrVld_d = addrVld_q;
        rd_d      = rd_q;
        err_d     = err_q;
        progAck_d = 1'b0;
        rdCnt_d   = rdCnt_q;
        wrCnt_d   = wrCnt_q;
        memWe     = 1'b0;
        memWaddr  = addr_q;
        memWdata  = bus.bus_in;

        if (state_q == PROG) begin
            if (bus.ale || bus.en) begin
                err_d = 1'b1;
            end
            if (!prog_req_i) begin
                state_d = IDLE;
            end
        end else if (bus.ale) begin
            addr_d    = bus.bus_in[AW-1:0];
            addrVld_d = 1'b1;
            state_d   = ADDR;
        end else if (bus.en && bus.rw) begin
            if (addrVld_q) begin
                rd_d    = mem_q[addr_q];
                rdCnt_d = (rdCnt_q == 16'hFFFF) ? rdCnt_q : rdCnt_q + 16'd1;
                state_d = RD;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end else if (bus.en) begin
            if (addrVld_q && !romHit) begin
                memWe   = 1'b1;
                wrCnt_d = (wrCnt_q == 16'hFFFF) ? wrCnt_q : wrCnt_q + 16'd1;
                state_d = WR;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        end else if ((state_q == IDLE) && prog_req_i) begin
            memWe     = 1'b1;
            memWaddr  = prog_addr_i[AW-1:0];
            memWdata  = prog_data_i;
            progAck_d = 1'b1;
            state_d   = PROG;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            addrVld_q <= 1'b0;
            rd_q      <= 8'h00;
            err_q     <= 1'b0;
            progAck_q <= 1'b0;
            rdCnt_q   <= 16'h0000;
            wrCnt_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            addrVld_q <= addrVld_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            progAck_q <= progAck_d;
            rdCnt_q   <= rdCnt_d;
            wrCnt_q   <= wrCnt_d;
        end
    end

    // Contents survive reset; writes are simply suppressed while reset is held.
    always_ff @(posedge clk_i) begin
        if (memWe && rst_ni) begin
            mem_q[memWaddr] <= memWdata;
        end
    end

    assign bus.bus_oe  = (state_q == RD);
    assign bus.bus_out = (state_q == RD) ? rd_q : 8'h00;
    assign prog_ack_o  = progAck_q;
    assign err_o       = err_q;
    assign rd_cnt_o    = rdCnt_q;
    assign wr_cnt_o    = wrCnt_q;

endmodule

// File: tb/tb_sam_mem_responder.sv
// Bench for sam_mem_responder: one open instance and one with a write-protected low region,
// both driven identically and compared every cycle against a transaction-level memory model.
module tb_sam_mem_responder;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        ale = 1'b0;
    logic        en = 1'b0;
    logic        rw = 1'b0;
    logic [7:0]  busIn = 8'h00;
    logic        progReq = 1'b0;
    logic [7:0]  progAddr = 8'h00;
    logic [7:0]  progData = 8'h00;

    logic        ackA, ackR, errA, errR;
    logic [15:0] rdA, wrA, rdR, wrR;

    sam_mem_responder_if busA();
    sam_mem_responder_if busR();

    assign busA.ale    = ale;
    assign busA.en     = en;
    assign busA.rw     = rw;
    assign busA.bus_in = busIn;
    assign busR.ale    = ale;
    assign busR.en     = en;
    assign busR.rw     = rw;
    assign busR.bus_in = busIn;

    sam_mem_responder #(.DEPTH(256), .ROM_TOP(0)) dut (
        .clk_i(clk), .rst_ni(rstN), .bus(busA),
        .prog_req_i(progReq), .prog_addr_i(progAddr), .prog_data_i(progData),
        .prog_ack_o(ackA), .err_o(errA), .rd_cnt_o(rdA), .wr_cnt_o(wrA)
    );

    sam_mem_responder #(.DEPTH(256), .ROM_TOP(64)) dutRom (
        .clk_i(clk), .rst_ni(rstN), .bus(busR),
        .prog_req_i(progReq), .prog_addr_i(progAddr), .prog_data_i(progData),
        .prog_ack_o(ackR), .err_o(errR), .rd_cnt_o(rdR), .wr_cnt_o(wrR)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: per instance, the memory image plus what the CPU should observe.
    logic [7:0] mMem [2][256];
    int         mAddr [2];
    bit         mVld [2];
    bit         mErr [2];
    bit         mDrive [2];
    logic [7:0] mOut [2];
    bit         mAck [2];
    bit         mProg [2];
    bit         mQuiet [2];
    int         mRd [2];
    int         mWr [2];
    logic [7:0] preVal [256];

    typedef struct {
        logic        a, e, r;
        logic [7:0]  b;
        logic        pr;
        logic [7:0]  pa, pd;
        logic        oe;
        logic [7:0]  out;
        logic        ack, err;
        logic [15:0] rd, wr;
    } vec_t;

    vec_t vecs [13];

    task automatic setVec(input int i, input logic a, e, r, input logic [7:0] b, input logic pr,
                          input logic [7:0] pa, pd, input logic oe, input logic [7:0] out,
                          input logic ack, err, input logic [15:0] rd, wr);
        vecs[i].a = a;   vecs[i].e = e;     vecs[i].r = r;     vecs[i].b = b;
        vecs[i].pr = pr; vecs[i].pa = pa;   vecs[i].pd = pd;
        vecs[i].oe = oe; vecs[i].out = out; vecs[i].ack = ack; vecs[i].err = err;
        vecs[i].rd = rd; vecs[i].wr = wr;
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mAddr[k] = 0;   mVld[k] = 0;  mErr[k] = 0;   mDrive[k] = 0; mOut[k] = 8'h00;
            mAck[k] = 0;    mProg[k] = 0; mQuiet[k] = 1; mRd[k] = 0;    mWr[k] = 0;
        end
    endtask

    // One clock edge of the responder, described as bus transactions rather than states.
    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            int romTop;
            romTop  = (k == 0) ? 0 : 64;
            mAck[k] = 0;
            mDrive[k] = 0;
            if (mProg[k]) begin
                if (ale || en) mErr[k] = 1;
                if (!progReq) begin
                    mProg[k]  = 0;
                    mQuiet[k] = 1;
                end
            end else if (ale) begin
                mAddr[k]  = int'(busIn) % 256;
                mVld[k]   = 1;
                mQuiet[k] = 0;
            end else if (en && rw) begin
                if (mVld[k]) begin
                    mOut[k]   = mMem[k][mAddr[k]];
                    mDrive[k] = 1;
                    mQuiet[k] = 0;
                    if (mRd[k] < 65535) mRd[k]++;
                end else begin
                    mErr[k]   = 1;
                    mQuiet[k] = 1;
                end
            end else if (en) begin
                if (mVld[k] && mAddr[k] >= romTop) begin
                    mMem[k][mAddr[k]] = busIn;
                    if (mWr[k] < 65535) mWr[k]++;
                    mQuiet[k] = 0;
                end else begin
                    mErr[k]   = 1;
                    mQuiet[k] = 1;
                end
            end else if (mQuiet[k] && progReq) begin
                mMem[k][progAddr] = progData;
                mAck[k]   = 1;
                mProg[k]  = 1;
                mQuiet[k] = 0;
            end else begin
                mQuiet[k] = 1;
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".A.oe"},  {15'b0, busA.bus_oe}, {15'b0, mDrive[0]});
        checkVal({tag, ".A.out"}, {8'b0, busA.bus_out}, {8'b0, mDrive[0] ? mOut[0] : 8'h00});
        checkVal({tag, ".A.ack"}, {15'b0, ackA},        {15'b0, mAck[0]});
        checkVal({tag, ".A.err"}, {15'b0, errA},        {15'b0, mErr[0]});
        checkVal({tag, ".A.rd"},  rdA,                  mRd[0][15:0]);
        checkVal({tag, ".A.wr"},  wrA,                  mWr[0][15:0]);
        checkVal({tag, ".R.oe"},  {15'b0, busR.bus_oe}, {15'b0, mDrive[1]});
        checkVal({tag, ".R.out"}, {8'b0, busR.bus_out}, {8'b0, mDrive[1] ? mOut[1] : 8'h00});
        checkVal({tag, ".R.ack"}, {15'b0, ackR},        {15'b0, mAck[1]});
        checkVal({tag, ".R.err"}, {15'b0, errR},        {15'b0, mErr[1]});
        checkVal({tag, ".R.rd"},  rdR,                  mRd[1][15:0]);
        checkVal({tag, ".R.wr"},  wrR,                  mWr[1][15:0]);
    endtask

    // Inputs change on the falling edge, the model advances on the rising edge, outputs are
    // sampled on the following falling edge.
    task automatic applyStimulus(input logic a, e, r, input logic [7:0] b, input logic pr,
                                 input logic [7:0] pa, pd, input string tag);
        ale = a; en = e; rw = r; busIn = b;
        progReq = pr; progAddr = pa; progData = pd;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic doReset();
        ale = 0; en = 0; rw = 0; progReq = 0;
        rstN = 1'b0;
        modelReset();
        #1;
        checkOutput("reset");
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mMem[k][i] = 8'h00;

        //      idx a  e  r  bus    pr pa     pd     oe out    ack err rd wr
        setVec(0,  0, 0, 0, 8'h00, 1, 8'h10, 8'h6A, 0, 8'h00, 1, 0, 0, 0);
        setVec(1,  0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        setVec(2,  1, 0, 0, 8'h10, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        setVec(3,  0, 1, 1, 8'h00, 0, 8'h00, 8'h00, 1, 8'h6A, 0, 0, 1, 0);
        setVec(4,  0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0);
        setVec(5,  1, 0, 0, 8'h20, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0);
        setVec(6,  0, 1, 0, 8'h5C, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 1);
        setVec(7,  0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 1);
        setVec(8,  0, 1, 1, 8'h00, 0, 8'h00, 8'h00, 1, 8'h5C, 0, 0, 2, 1);
        setVec(9,  0, 1, 1, 8'h00, 0, 8'h00, 8'h00, 1, 8'h5C, 0, 0, 3, 1);
        setVec(10, 1, 1, 1, 8'h30, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3, 1);
        setVec(11, 1, 1, 0, 8'h30, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3, 1);
        setVec(12, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 3, 1);

        modelReset();
        @(negedge clk);
        checkOutput("reset");
        @(negedge clk);
        rstN = 1'b1;

        // Fill every word of both memories through the program port.
        for (int i = 0; i < 256; i++) begin
            preVal[i] = 8'($urandom);
            applyStimulus(0, 0, 0, 8'h00, 1, 8'(i), preVal[i], "preload");
            applyStimulus(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, "preloadRel");
        end

        // Write protection below 0x40 on the second instance; the program port ignores it.
        applyStimulus(1, 0, 0, 8'h05, 0, 8'h00, 8'h00, "romAle");
        applyStimulus(0, 1, 0, 8'h99, 0, 8'h00, 8'h00, "romWr");
        checkVal("romWr.R.errSet", {15'b0, errR}, 16'd1);
        checkVal("romWr.A.errClr", {15'b0, errA}, 16'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, "romIdle");
        applyStimulus(1, 0, 0, 8'h05, 0, 8'h00, 8'h00, "romAle2");
        applyStimulus(0, 1, 1, 8'h00, 0, 8'h00, 8'h00, "romRd");
        checkVal("romRd.R.kept", {8'b0, busR.bus_out}, {8'b0, preVal[5]});
        checkVal("romRd.A.new",  {8'b0, busA.bus_out}, 16'h0099);
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, "romIdle2");
        applyStimulus(0, 0, 0, 8'h00, 1, 8'h05, 8'hA5, "romProg");
        checkVal("romProg.R.ack", {15'b0, ackR}, 16'd1);
        applyStimulus(0, 0, 0, 8'h00, 1, 8'h05, 8'hA5, "romProgHold");
        checkVal("romProgHold.R.ack", {15'b0, ackR}, 16'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, "romProgRel");
        applyStimulus(1, 0, 0, 8'h05, 0, 8'h00, 8'h00, "romAle3");
        applyStimulus(0, 1, 1, 8'h00, 0, 8'h00, 8'h00, "romRd2");
        checkVal("romRd2.R.prog", {8'b0, busR.bus_out}, 16'h00A5);
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, "romIdle3");

        doReset();
        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].a, vecs[i].e, vecs[i].r, vecs[i].b, vecs[i].pr,
                          vecs[i].pa, vecs[i].pd, tag);
            checkVal({tag, ".tab.oe"},  {15'b0, busA.bus_oe}, {15'b0, vecs[i].oe});
            checkVal({tag, ".tab.out"}, {8'b0, busA.bus_out}, {8'b0, vecs[i].out});
            checkVal({tag, ".tab.ack"}, {15'b0, ackA},        {15'b0, vecs[i].ack});
            checkVal({tag, ".tab.err"}, {15'b0, errA},        {15'b0, vecs[i].err});
            checkVal({tag, ".tab.rd"},  rdA,                  vecs[i].rd);
            checkVal({tag, ".tab.wr"},  wrA,                  vecs[i].wr);
        end

        // The combined ale+en cycles latched 0x30 without a new ALE being needed now.
        applyStimulus(0, 1, 1, 8'h00, 0, 8'h00, 8'h00, "rd30");
        checkVal("rd30.A.data", {8'b0, busA.bus_out}, {8'b0, preVal[8'h30]});
        checkVal("rd30.A.rd",   rdA, 16'd4);

        // Reset in the middle of a read drops bus_oe without waiting for a clock edge.
        rstN = 1'b0;
        modelReset();
        #1;
        checkVal("midRst.A.oe", {15'b0, busA.bus_oe}, 16'd0);
        checkVal("midRst.R.oe", {15'b0, busR.bus_oe}, 16'd0);
        checkOutput("midRst");
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 1, 1, 8'h00, 0, 8'h00, 8'h00, "noAleRd");
        checkVal("noAleRd.A.err", {15'b0, errA}, 16'd1);
        checkVal("noAleRd.A.oe",  {15'b0, busA.bus_oe}, 16'd0);
        checkVal("noAleRd.A.rd",  rdA, 16'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, "noAleIdle");

        doReset();
        for (int n = 0; n < 800; n++) begin
            logic a, e, r, pr;
            a  = ($urandom_range(0, 4) == 0);
            e  = ($urandom_range(0, 9) < 4);
            r  = 1'($urandom);
            pr = ($urandom_range(0, 5) == 0);
            applyStimulus(a, e, r, 8'($urandom), pr, 8'($urandom), 8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
